display_scanner: RTL and testbench
==================================

// Module: display_scanner
// PURPOSE
// - Consumes the bicycle computer's static display bus: six segment bytes plus the
//   AVS/DAY/MAX/TIM/col/point flags.
// - Drives a physical time-multiplexed 7-segment panel with one shared segment bus
//   and seven active-low digit enables: six digits plus one annunciator slot.
// - Snapshots the bus once per frame so the panel never shows a torn mix of two readings.
// - Provides inter-digit blanking against ghosting and brightness PWM.
// PARAMETERS
// - SCAN_DIV      default 500  clock cycles per digit slot; must be >= BLANK_CYC + 2.
// - BLANK_CYC     default 20   cycles at the start of each slot with all digits off.
// - BRIGHT_WIDTH  default 3    width of the brightness input.
// PORTS
// - clock        in   1             system clock, single clock domain
// - reset        in   1             asynchronous, active-low reset
// - lower0001    in   8             digit 0 segments, active-high {dp,g,f,e,d,c,b,a}
// - lower0010    in   8             digit 1 segments, same format
// - lower0100    in   8             digit 2 segments, same format
// - lower1000    in   8             digit 3 segments, same format
// - upper01      in   8             digit 4 segments, same format
// - upper10      in   8             digit 5 segments, same format
// - AVS,DAY,MAX,TIM,col,point  in  1 each   annunciator flags
// - bright       in   BRIGHT_WIDTH  duty level; 0 = dimmest, all-ones = full
// - lamp_test    in   1             forces all segments lit in every slot
// - seg_n        out  8             panel segment bus, active-low
// - dig_n        out  7             one-cold digit enables; bit 6 = annunciator slot
// - frame_pulse  out  1             1-cycle pulse at each frame wrap
// BEHAVIOUR
// - Reset values (async, reset==0):
//   - cnt=0, slot=0, snapshot regs=0.
//   - seg_n=8'hFF, dig_n=7'h7F, frame_pulse=0.
// - Scan counting:
//   - cnt counts 0..SCAN_DIV-1.
//   - At cnt==SCAN_DIV-1: cnt goes to 0 and slot increments, wrapping 6 -> 0.
// - Frame wrap, i.e. cnt==SCAN_DIV-1 and slot==6:
//   - Snapshot captures all 6 bytes, the 6 flags and bright.
//   - frame_pulse=1 on the following cycle.
//   - The first frame after reset shows the zeroed snapshot, which is a blank panel.
// - Slot byte sel:
//   - Slots 0..5 show snapshot lower0001..upper10.
//   - Slot 6 shows {col,point,AVS,DAY,MAX,TIM,2'b00}.
//   - lamp_test (live, not snapshotted) forces sel=8'hFF.
// - on_len = ((SCAN_DIV-BLANK_CYC)*(bright_snap+1)) >> BRIGHT_WIDTH.
//   Compute it once per frame into a register and never in the per-cycle path.
// - Digit window: lit iff BLANK_CYC <= cnt < BLANK_CYC+on_len.
// - Output timing: all outputs are registered and reflect the counter state of the
//   previous cycle, i.e. 1-cycle latency.
//   - Lit:   dig_n = ~(7'b1 << slot), seg_n = ~sel.
//   - Unlit: dig_n = 7'h7F, seg_n = 8'hFF.
// - Invariant: at most one dig_n bit is low in any cycle.
//   dig_n and seg_n change only on the same edge.
// - Inputs are sampled only at the frame wrap. Input changes mid-frame have no
//   visible effect until the next frame.
// - Reset asserted mid-slot blanks the outputs immediately (async).
//   Scanning restarts at slot 0, cnt 0.
// - If on_len == 0 (possible with small SCAN_DIV), the digit stays dark for the whole slot.
// STRUCTURE
// - Shared package holds:
//   - NUM_SLOTS=7, ANN_SLOT=6.
//   - SEG_OFF=8'hFF, DIG_OFF=7'h7F.
//   - Annunciator bit positions: COL=7, POINT=6, AVS=5, DAY=4, MAX=3, TIM=2.
// - One sub-module, scan_timer: owns cnt, slot and frame wrap detection.
//   It outputs cnt, slot and a wrap strobe.
// - The top holds the snapshot, on_len, the sel mux and the output regs.
// TESTING  (SCAN_DIV=8, BLANK_CYC=2, BRIGHT_WIDTH=2)
// - Reset held 5 cycles, then released -> seg_n=FF, dig_n=7F throughout reset.
//   After release: frame_pulse at cycle 56, dig_n all 7F for frame 0.
// - lower0001=8'h3F, bright=3 -> in frame 1, slot 0 shows dig_n=7E and seg_n=C0
//   for exactly 6 cycles (cnt 2..7), then 2 cycles of 7F/FF.
// - bright=1 -> each slot is lit 3 cycles; bright=0 -> each slot is lit 1 cycle.
//   The duty change applies only from the next frame wrap.
// - Change upper10 mid-frame (during slot 2) -> slot 5 of the same frame still shows
//   the old value; the next frame shows the new value.
// - AVS=1, col=1, all others 0 -> slot 6: dig_n=3F, seg_n=~8'hA0=5F.
// - Assert reset during slot 3 -> outputs go to FF/7F in the same cycle (async).
//   After release the scan restarts at slot 0.
// - Randomized bytes over 100 frames; checker confirms:
//   - at most one dig_n bit is low per cycle;
//   - frame_pulse period is 56 cycles.

Source files
------------

// File: rtl/display_scanner_pkg.sv
// Shared constants for the multiplexed display scanner: slot map, idle levels,
// and bit positions of the annunciator byte shown in the extra slot.
package display_scanner_pkg;

    localparam int NUM_SLOTS = 7;
    localparam int ANN_SLOT  = 6;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [6:0] DIG_OFF = 7'h7F;

    localparam int ANN_COL   = 7;
    localparam int ANN_POINT = 6;
    localparam int ANN_AVS   = 5;
    localparam int ANN_DAY   = 4;
    localparam int ANN_MAX   = 3;
    localparam int ANN_TIM   = 2;

    function automatic logic [7:0] ann_byte(input logic col, input logic point,
                                            input logic avs, input logic day,
                                            input logic max, input logic tim);
        logic [7:0] b;
        b            = '0;
        b[ANN_COL]   = col;
        b[ANN_POINT] = point;
        b[ANN_AVS]   = avs;
        b[ANN_DAY]   = day;
        b[ANN_MAX]   = max;
        b[ANN_TIM]   = tim;
        return b;
    endfunction

endpackage

// File: rtl/display_scanner_scan_timer.sv
// Slot timer: cnt runs 0..SCAN_DIV-1 per slot, slot runs 0..NUM_SLOTS-1 per frame.
// Latency: wrap_o is combinational from the current state; free-running, no backpressure.
module display_scanner_scan_timer
    import display_scanner_pkg::*;
#(
    parameter int SCAN_DIV = 500,
    parameter int CW       = $clog2(SCAN_DIV)
) (
    input  logic          clock,
    input  logic          reset,
    output logic [CW-1:0] cnt_o,
    output logic [2:0]    slot_o,
    output logic          wrap_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    slot_q, slot_d;
    logic          slot_end;

    assign slot_end = (cnt_q == CW'(SCAN_DIV - 1));
    assign wrap_o   = slot_end && (slot_q == 3'(NUM_SLOTS - 1));
    assign cnt_o    = cnt_q;
    assign slot_o   = slot_q;

    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        slot_d = slot_q;
        if (slot_end) begin
            cnt_d  = '0;
            slot_d = wrap_o ? 3'd0 : slot_q + 3'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            slot_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Drives a 7-slot multiplexed 7-segment panel from a per-frame snapshot of the display bus.
// Latency: outputs registered, 1 cycle behind the scan counter; free-running, no backpressure.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int SCAN_DIV     = 500,
    parameter int BLANK_CYC    = 20,
    parameter int BRIGHT_WIDTH = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              lower0001,
    input  logic [7:0]              lower0010,
    input  logic [7:0]              lower0100,
    input  logic [7:0]              lower1000,
    input  logic [7:0]              upper01,
    input  logic [7:0]              upper10,
    input  logic                    AVS,
    input  logic                    DAY,
    input  logic                    MAX,
    input  logic                    TIM,
    input  logic                    col,
    input  logic                    point,
    input  logic [BRIGHT_WIDTH-1:0] bright,
    input  logic                    lamp_test,
    output logic [7:0]              seg_n,
    output logic [6:0]              dig_n,
    output logic                    frame_pulse
);

    localparam int CW  = $clog2(SCAN_DIV);
    localparam int OLW = CW + 1;

    logic [CW-1:0] cnt;
    logic [2:0]    slot;
    logic          wrap;

    display_scanner_scan_timer #(
        .SCAN_DIV (SCAN_DIV),
        .CW       (CW)
    ) u_scan_timer (
        .clock  (clock),
        .reset  (reset),
        .cnt_o  (cnt),
        .slot_o (slot),
        .wrap_o (wrap)
    );

    logic [5:0][7:0] snap_q;
    logic [7:0]      ann_q;
    logic [OLW-1:0]  on_len_q, on_len_d;

    // Window length is derived from the live brightness at the same edge the snapshot is taken.
    assign on_len_d = OLW'((32'(SCAN_DIV - BLANK_CYC) * (32'(bright) + 32'd1)) >> BRIGHT_WIDTH);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snap_q   <= '0;
            ann_q    <= '0;
            on_len_q <= '0;
        end else if (wrap) begin
            snap_q   <= {upper10, upper01, lower1000, lower0100, lower0010, lower0001};
            ann_q    <= ann_byte(col, point, AVS, DAY, MAX, TIM);
            on_len_q <= on_len_d;
        end
    end

    logic [OLW-1:0] cnt_ext;
    logic           lit;
    logic [7:0]     sel;

    assign cnt_ext = OLW'(cnt);
    assign lit     = (cnt_ext >= OLW'(BLANK_CYC)) && ((cnt_ext - OLW'(BLANK_CYC)) < on_len_q);

    always_comb begin
        sel = ann_q;
        case (slot)
            3'd0:    sel = snap_q[0];
            3'd1:    sel = snap_q[1];
            3'd2:    sel = snap_q[2];
            3'd3:    sel = snap_q[3];
            3'd4:    sel = snap_q[4];
            3'd5:    sel = snap_q[5];
            default: sel = ann_q;
        endcase
        if (lamp_test) sel = 8'hFF;
    end

    logic [7:0] seg_q, seg_d;
    logic [6:0] dig_q, dig_d;
    logic       fp_q;

    assign seg_d = lit ? ~sel : SEG_OFF;
    assign dig_d = lit ? ~(7'b1 << slot) : DIG_OFF;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_q <= SEG_OFF;
            dig_q <= DIG_OFF;
            fp_q  <= 1'b0;
        end else begin
            seg_q <= seg_d;
            dig_q <= dig_d;
            fp_q  <= wrap;
        end
    end

    assign seg_n       = seg_q;
    assign dig_n       = dig_q;
    assign frame_pulse = fp_q;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner with SCAN_DIV=8, BLANK_CYC=2, BRIGHT_WIDTH=2.
module tb_display_scanner;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int BW    = 2;
    localparam int FRAME = SD * 7;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    lower0001, lower0010, lower0100, lower1000, upper01, upper10;
    logic          AVS, DAY, MAX, TIM, col, point;
    logic [BW-1:0] bright;
    logic          lamp_test;
    logic [7:0]    seg_n;
    logic [6:0]    dig_n;
    logic          frame_pulse;

    display_scanner #(
        .SCAN_DIV     (SD),
        .BLANK_CYC    (BC),
        .BRIGHT_WIDTH (BW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .lower0001   (lower0001),
        .lower0010   (lower0010),
        .lower0100   (lower0100),
        .lower1000   (lower1000),
        .upper01     (upper01),
        .upper10     (upper10),
        .AVS         (AVS),
        .DAY         (DAY),
        .MAX         (MAX),
        .TIM         (TIM),
        .col         (col),
        .point       (point),
        .bright      (bright),
        .lamp_test   (lamp_test),
        .seg_n       (seg_n),
        .dig_n       (dig_n),
        .frame_pulse (frame_pulse)
    );

    initial forever #5 clock = ~clock;

    typedef struct packed {
        logic       lit;
        logic [2:0] slot;
        logic [7:0] sel;
        logic       fp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   k        = 0;
    logic lamp_e   = 1'b0;
    int   last_fp  = 0;
    int   f1_lit   = 0;
    bit   f1_done  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    function automatic int on_len_of(input logic [BW-1:0] b);
        return ((SD - BC) * (int'(b) + 1)) >> BW;
    endfunction

    // Expected outputs for one whole frame, built from the bus as it stands at the capture edge.
    task automatic push_frame(input bit zero);
        logic [7:0] bytes [6];
        logic [7:0] ann;
        int         ol;
        exp_t       e;
        if (zero) begin
            for (int i = 0; i < 6; i++) bytes[i] = 8'h00;
            ann = 8'h00;
            ol  = 0;
        end else begin
            bytes[0] = lower0001; bytes[1] = lower0010; bytes[2] = lower0100;
            bytes[3] = lower1000; bytes[4] = upper01;   bytes[5] = upper10;
            ann = {col, point, AVS, DAY, MAX, TIM, 2'b00};
            ol  = on_len_of(bright);
        end
        for (int p = 0; p < FRAME; p++) begin
            int c, s;
            c      = p % SD;
            s      = p / SD;
            e.lit  = (c >= BC) && ((c - BC) < ol);
            e.slot = 3'(s);
            e.sel  = (s < 6) ? bytes[s] : ann;
            e.fp   = (p == FRAME - 1);
            exp_q.push_back(e);
        end
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            k      <= 0;
            lamp_e <= 1'b0;
        end else begin
            k      <= k + 1;
            lamp_e <= lamp_test;
        end
    end

    always @(posedge clock) begin
        if (reset && (k == 0 || (k % FRAME) == FRAME - 1)) push_frame(k == 0);
    end

    always @(negedge clock) begin
        exp_t       e;
        logic [6:0] ed;
        logic [7:0] es;
        if (!reset) begin
            exp_q.delete();
            last_fp = 0;
            check("rst_seg", seg_n, 8'hFF);
            check("rst_dig", dig_n, 7'h7F);
            check("rst_fp", frame_pulse, 1'b0);
        end else if (k == 0) begin
            check("idle_seg", seg_n, 8'hFF);
            check("idle_dig", dig_n, 7'h7F);
        end else begin
            check("dig_onehot", ($countones(~dig_n) <= 1), 1);
            if (exp_q.size() == 0) begin
                check("sb_empty", exp_q.size(), 1);
            end else begin
                e  = exp_q.pop_front();
                ed = e.lit ? ~(7'b1 << e.slot) : 7'h7F;
                es = e.lit ? ~(lamp_e ? 8'hFF : e.sel) : 8'hFF;
                check("dig", dig_n, ed);
                check("seg", seg_n, es);
                check("fp", frame_pulse, e.fp);
            end
            if (!f1_done && k >= 57 && k <= 64 && dig_n == 7'h7E && seg_n == 8'hC0) f1_lit++;
            if (frame_pulse) begin
                if (last_fp == 0) check("fp_first", k, FRAME);
                else              check("fp_period", k - last_fp, FRAME);
                last_fp = k;
            end
        end
    end

    task automatic goto(input int target);
        while (k < target) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        {lower0001, lower0010, lower0100, lower1000, upper01, upper10} = '0;
        {AVS, DAY, MAX, TIM, col, point} = '0;
        bright    = '0;
        lamp_test = 1'b0;
        repeat (5) @(posedge clock);
        #1 reset = 1'b1;

        lower0001 = 8'h3F;
        bright    = 2'd3;
        goto(60);
        bright    = 2'd1;
        upper10   = 8'h06;
        goto(70);
        check("f1_slot0_lit", f1_lit, 6);
        f1_done   = 1'b1;
        // Changed during slot 2 of frame 2: frame 2 must still show 06 in slot 5.
        goto(132);
        upper10   = 8'h5B;
        bright    = 2'd0;
        goto(170);
        lower0001 = 8'h00;
        upper10   = 8'h00;
        AVS       = 1'b1;
        col       = 1'b1;
        bright    = 2'd3;
        goto(226);
        lamp_test = 1'b1;
        lower1000 = 8'h4F;
        goto(240);
        lamp_test = 1'b0;

        goto(309);
        check("pre_rst_dig", dig_n, 7'h77);
        check("pre_rst_seg", seg_n, 8'hB0);
        #3 reset = 1'b0;
        #1;
        check("async_rst_dig", dig_n, 7'h7F);
        check("async_rst_seg", seg_n, 8'hFF);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        for (int f = 0; f < 100; f++) begin
            goto(FRAME * f + 10);
            lower0001 = 8'($urandom);
            lower0010 = 8'($urandom);
            lower0100 = 8'($urandom);
            lower1000 = 8'($urandom);
            upper01   = 8'($urandom);
            upper10   = 8'($urandom);
            {AVS, DAY, MAX, TIM, col, point} = 6'($urandom);
            bright    = BW'($urandom);
        end
        goto(FRAME * 101 + 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
